// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared definitions for the UART transmit path: byte width, the packet
//   sequencer's state encodings and the baud_set codes understood by
//   uart_byte_tx.
//   No ports (package).
package uart_tx_pkg;

    localparam int BYTE_W = 8;

    // Packet sequencer states (2-bit encoding kept for older debug tooling)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // baud_set codes for uart_byte_tx
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the winner is the first set bit of pend
//   at or above ptr, wrapping around to bit 0.
// Ports
//   pend    in   NUM_REQ  pending request bits
//   ptr     in   PW       highest-priority requester index
//   winner  out  NUM_REQ  one-hot winner, zero when nothing is pending
//   valid   out  1        at least one request pending
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    always_comb begin
        logic [PW:0] pos;
        winner = '0;
        pos    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr + k modulo NUM_REQ; one extra bit keeps the sum from overflowing
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(NUM_REQ)) begin
                pos = pos - (PW+1)'(NUM_REQ);
            end
            if (winner == '0 && pend[pos[PW-1:0]]) begin
                winner[pos[PW-1:0]] = 1'b1;
            end
        end
    end

    assign valid = |pend;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_byte_tx between NUM_REQ packet producers. Each requester
//   posts a packet of up to MAX_BYTES bytes; a round-robin arbiter grants one
//   packet at a time and the packet is fed LSB byte first to the byte
//   transmitter.
//   Byte handshake: send_go is a one-cycle start pulse with Data valid in the
//   same cycle and held until the next send_go; tx_done is a one-cycle pulse
//   in the Clk domain that completes the byte. tx_done outside WAIT is ignored.
// Ports
//   Clk       in   1                    system clock
//   Reset     in   1                    asynchronous, active-high reset
//   Req_Go    in   NUM_REQ              request pulse/level per requester
//   Req_Data  in   NUM_REQ*MAX_BYTES*8  payloads, requester i at [i*MAX_BYTES*8 +: MAX_BYTES*8]
//   Req_Len   in   NUM_REQ*LW           byte counts, requester i at [i*LW +: LW]
//   Req_Done  out  NUM_REQ              one-cycle pulse when a packet is fully sent
//   Grant     out  NUM_REQ              one-hot current owner, zero when idle
//   Busy      out  1                    a packet is owned
//   Data      out  8                    byte to uart_byte_tx
//   send_go   out  1                    start pulse to uart_byte_tx
//   tx_done   in   1                    byte-complete pulse from uart_byte_tx
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BYTES = 5,
    localparam int LW        = $clog2(MAX_BYTES+1)
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             Req_Go,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] Req_Data,
    input  logic [NUM_REQ*LW-1:0]          Req_Len,
    output logic [NUM_REQ-1:0]             Req_Done,
    output logic [NUM_REQ-1:0]             Grant,
    output logic                           Busy,
    output logic [BYTE_W-1:0]              Data,
    output logic                           send_go,
    input  logic                           tx_done
);

    localparam int PKT_W = MAX_BYTES*BYTE_W;
    localparam int PW    = $clog2(NUM_REQ);

    logic [1:0]         state_q;
    logic [NUM_REQ-1:0] pend_q;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] grant_clr;
    logic               win_valid;
    logic               take;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      owner_q;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      next_ptr;
    logic [PKT_W-1:0]   pkt_q;
    logic [PKT_W-1:0]   sel_data;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      idx_q;
    logic [LW-1:0]      sel_len;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .pend    (pend_q),
        .ptr     (ptr_q),
        .winner  (win_oh),
        .valid   (win_valid)
    );

    // Route the winner's payload and clamped length toward the snapshot registers
    always_comb begin
        win_idx  = '0;
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = PW'(i);
                sel_data = Req_Data[i*PKT_W +: PKT_W];
                sel_len  = Req_Len[i*LW +: LW];
            end
        end
        if (sel_len > LW'(MAX_BYTES)) begin
            sel_len = LW'(MAX_BYTES);
        end
    end

    assign take      = (state_q == ST_IDLE) && win_valid;
    assign grant_clr = take ? win_oh : '0;
    assign next_ptr  = (owner_q == PW'(NUM_REQ-1)) ? '0 : owner_q + PW'(1);

    // A Go arriving on the very edge its requester is granted is absorbed by that grant
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q | Req_Go) & ~grant_clr;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            pkt_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            Req_Done <= '0;
            Grant    <= '0;
            Busy     <= 1'b0;
            Data     <= '0;
            send_go  <= 1'b0;
        end else begin
            Req_Done <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        pkt_q   <= sel_data;
                        len_q   <= sel_len;
                        owner_q <= win_idx;
                        Grant   <= win_oh;
                        Busy    <= 1'b1;
                        idx_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (len_q == '0) begin
                        // Empty packet: complete without touching the transmitter
                        Req_Done <= Grant;
                        Grant    <= '0;
                        Busy     <= 1'b0;
                        ptr_q    <= next_ptr;
                        state_q  <= ST_IDLE;
                    end else begin
                        // Snapshot is consumed as a shift register, low byte first
                        Data    <= pkt_q[BYTE_W-1:0];
                        pkt_q   <= pkt_q >> BYTE_W;
                        send_go <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    send_go <= 1'b0;
                    if (tx_done) begin
                        if (idx_q == len_q - LW'(1)) begin
                            Req_Done <= Grant;
                            Grant    <= '0;
                            Busy     <= 1'b0;
                            ptr_q    <= next_ptr;
                            state_q  <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + LW'(1);
                            state_q <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int MB    = 5;
    localparam int LW    = $clog2(MB+1);
    localparam int PKT_W = MB*8;
    localparam int TX_LAT = 20;

    logic                 Clk;
    logic                 Reset;
    logic [N-1:0]         Req_Go;
    logic [N*PKT_W-1:0]   Req_Data;
    logic [N*LW-1:0]      Req_Len;
    logic [N-1:0]         Req_Done;
    logic [N-1:0]         Grant;
    logic                 Busy;
    logic [7:0]           Data;
    logic                 send_go;
    logic                 tx_done;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .MAX_BYTES (MB)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req_Go   (Req_Go),
        .Req_Data (Req_Data),
        .Req_Len  (Req_Len),
        .Req_Done (Req_Done),
        .Grant    (Grant),
        .Busy     (Busy),
        .Data     (Data),
        .send_go  (send_go),
        .tx_done  (tx_done)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [PKT_W-1:0] pkt_data [N];
    logic [LW-1:0]    pkt_len  [N];

    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    int         exp_order[$];
    int         done_q[$];
    int         grant_q[$];
    int         go_cnt = 0;
    int         tx_cnt = 0;
    int         mptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- byte transmitter model + monitor ----------------
    initial begin
        logic [N-1:0] last_grant;
        last_grant = '0;
        tx_done = 1'b0;
        forever begin
            @(negedge Clk);
            tx_done = 1'b0;
            if (Reset) begin
                tx_cnt = 0;
                last_grant = '0;
            end else begin
                chk("busy_vs_grant", 32'(Busy), 32'(Grant != '0));
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) tx_done = 1'b1;
                end
                if (send_go) begin
                    sent_q.push_back(Data);
                    go_cnt++;
                    tx_cnt = TX_LAT;
                end
                for (int i = 0; i < N; i++) begin
                    if (Req_Done[i]) done_q.push_back(i);
                end
                if (last_grant == '0 && Grant != '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (Grant[i]) grant_q.push_back(i);
                    end
                end
                last_grant = Grant;
            end
        end
    end

    // ---------------- reference model ----------------
    // Serves the pending set in round-robin order from mptr; 'late' requests
    // join the pending set once the first packet of the batch is granted.
    task automatic model_run(input logic [N-1:0] mask, input logic [N-1:0] late);
        logic [N-1:0] p;
        bit first;
        int w;
        int n;
        p = mask;
        first = 1'b1;
        while (p != '0) begin
            w = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (p[j]) begin
                    w = j;
                    break;
                end
            end
            p[w] = 1'b0;
            if (first) begin
                p = p | late;
                first = 1'b0;
            end
            exp_order.push_back(w);
            n = (int'(pkt_len[w]) > MB) ? MB : int'(pkt_len[w]);
            for (int b = 0; b < n; b++) exp_q.push_back(pkt_data[w][b*8 +: 8]);
            mptr = (w + 1) % N;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            Req_Data[i*PKT_W +: PKT_W] = pkt_data[i];
            Req_Len[i*LW +: LW]        = pkt_len[i];
        end
    endtask

    task automatic issue(input logic [N-1:0] mask);
        @(negedge Clk);
        Req_Go = mask;
        @(negedge Clk);
        Req_Go = '0;
    endtask

    task automatic clear_logs();
        exp_q.delete(); sent_q.delete(); exp_order.delete();
        done_q.delete(); grant_q.delete(); go_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        clear_logs();
        mptr = 0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int c;
        c = 0;
        while (done_q.size() < n && c < 3000) begin
            @(negedge Clk);
            c++;
        end
        chk({tag, "_timeout"}, 32'(done_q.size() >= n), 32'd1);
        repeat (TX_LAT + 10) @(negedge Clk);
    endtask

    task automatic wait_grant(input string tag);
        int c;
        c = 0;
        while (grant_q.size() < 1 && c < 200) begin
            @(negedge Clk);
            c++;
        end
        chk({tag, "_grant_timeout"}, 32'(grant_q.size() >= 1), 32'd1);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_done_cnt"}, 32'(done_q.size()), 32'(exp_order.size()));
        for (int k = 0; k < done_q.size() && k < exp_order.size(); k++)
            chk({tag, "_done_order"}, 32'(done_q[k]), 32'(exp_order[k]));
        chk({tag, "_grant_cnt"}, 32'(grant_q.size()), 32'(exp_order.size()));
        for (int k = 0; k < grant_q.size() && k < exp_order.size(); k++)
            chk({tag, "_grant_order"}, 32'(grant_q[k]), 32'(exp_order[k]));
        chk({tag, "_go_cnt"}, 32'(go_cnt), 32'(exp_q.size()));
        for (int k = 0; k < sent_q.size() && k < exp_q.size(); k++)
            chk({tag, "_byte"}, 32'(sent_q[k]), 32'(exp_q[k]));
        chk({tag, "_idle_grant"}, 32'(Grant), 32'd0);
        chk({tag, "_idle_busy"}, 32'(Busy), 32'd0);
        clear_logs();
    endtask

    task automatic randomize_pkts(input int lo, input int hi);
        for (int i = 0; i < N; i++) begin
            pkt_data[i] = {8'($urandom), 32'($urandom)};
            pkt_len[i]  = LW'($urandom_range(hi, lo));
        end
        apply_inputs();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [N-1:0] mask;
        logic [15:0]  hi16;
        int           c;

        Reset = 1'b1;
        Req_Go = '0;
        Req_Data = '0;
        Req_Len = '0;
        for (int i = 0; i < N; i++) begin
            pkt_data[i] = '0;
            pkt_len[i]  = '0;
        end
        repeat (3) @(negedge Clk);
        chk("rst_req_done", 32'(Req_Done), 32'd0);
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_data", 32'(Data), 32'd0);
        chk("rst_send_go", 32'(send_go), 32'd0);
        Reset = 1'b0;
        mptr = 0;

        // Single 3-byte packet from requester 0
        hi16 = 16'($urandom);
        pkt_data[0] = {hi16, 24'h332211};
        pkt_len[0]  = 3;
        apply_inputs();
        model_run(4'b0001, '0);
        chk("t1_model_first_byte", 32'(exp_q[0]), 32'h11);
        issue(4'b0001);
        wait_done("t1", 1);
        check_results("t1");

        // All requesters at once, 2 bytes each, from a fresh pointer
        do_reset();
        randomize_pkts(2, 2);
        model_run(4'b1111, '0);
        issue(4'b1111);
        wait_done("t2", 4);
        check_results("t2");

        // Requester 1 re-posts during its own transfer while 2 waits
        randomize_pkts(1, 3);
        model_run(4'b0110, 4'b0010);
        issue(4'b0110);
        wait_grant("t3");
        repeat (5) @(negedge Clk);
        issue(4'b0010);
        wait_done("t3", 3);
        check_results("t3");

        // Empty packet on requester 3
        randomize_pkts(1, 5);
        pkt_len[3] = 0;
        apply_inputs();
        model_run(4'b1000, '0);
        issue(4'b1000);
        wait_done("t4_len0", 1);
        check_results("t4_len0");

        // Oversized length clamps to MAX_BYTES
        pkt_len[0] = 7;
        apply_inputs();
        model_run(4'b0001, '0);
        issue(4'b0001);
        wait_done("t4_len7", 1);
        check_results("t4_len7");

        // Inputs changed after the grant must not reach the line
        pkt_len[2] = 4;
        apply_inputs();
        model_run(4'b0100, '0);
        issue(4'b0100);
        wait_grant("t5");
        pkt_data[2] = ~pkt_data[2];
        pkt_len[2]  = 1;
        apply_inputs();
        wait_done("t5", 1);
        check_results("t5");

        // Reset between bytes 2 and 3 of a 5-byte packet
        pkt_len[3] = 5;
        apply_inputs();
        issue(4'b1000);
        c = 0;
        while (go_cnt < 2 && c < 500) begin
            @(negedge Clk);
            c++;
        end
        chk("t6_reach_byte2", 32'(go_cnt >= 2), 32'd1);
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("t6_abort_grant", 32'(Grant), 32'd0);
        chk("t6_abort_busy", 32'(Busy), 32'd0);
        chk("t6_abort_send_go", 32'(send_go), 32'd0);
        chk("t6_abort_data", 32'(Data), 32'd0);
        chk("t6_abort_done", 32'(Req_Done), 32'd0);
        repeat (2) @(negedge Clk);
        chk("t6_no_done", 32'(done_q.size()), 32'd0);
        Reset = 1'b0;
        clear_logs();
        mptr = 0;
        randomize_pkts(1, 3);
        model_run(4'b1001, '0);
        issue(4'b1001);
        wait_done("t6_after", 2);
        check_results("t6_after");

        // Random batches
        for (int r = 0; r < 6; r++) begin
            randomize_pkts(0, 7);
            mask = N'($urandom_range(15, 1));
            model_run(mask, '0);
            issue(mask);
            wait_done("rand", $countones(mask));
            check_results("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
